seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter: W, 32, operand/result width in bits (>= 4).
REQ-002 Parameter: SIGNED, 1, 1 = two's-complement operands and results, 0 = unsigned.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: start  input  1  request; sampled only in IDLE.
REQ-006 Port: dividend  input  W  numerator; captured on accepted start.
REQ-007 Port: divisor  input  W  denominator; captured on accepted start.
REQ-008 Port: busy  output  1  high from the cycle after accept until done inclusive.
REQ-009 Port: done  output  1  one-cycle pulse; results valid.
REQ-010 Port: quotient  output  W  result; held until the next accepted start.
REQ-011 Port: remainder  output  W  result; held until the next accepted start.
REQ-012 Port: div_by_zero  output  1  flag for the last result; held with the results.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-014 IDLE with start=1 SHALL capture both operands and record their signs when SIGNED=1.
REQ-015 IDLE with start=1 SHALL load absolute magnitudes, load iteration counter = W, and go to CALC.
REQ-016 CALC SHALL perform one radix-2 non-restoring step per cycle on a (W+1)-bit partial remainder.
REQ-017 CALC SHALL decrement the counter each step and go to FIX after exactly W steps.
REQ-018 FIX SHALL apply the final remainder restore if the partial remainder is negative.
REQ-019 FIX SHALL negate the quotient when operand signs differ.
REQ-020 FIX SHALL negate the remainder when the dividend is negative, then go to DONE.
REQ-021 DONE SHALL drive done=1 for exactly one cycle, then return to IDLE.
REQ-022 Latency: done SHALL be high exactly W+2 cycles after the cycle in which start was accepted.
REQ-023 Rounding SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign; the remainder SHALL be 0 or have magnitude < |divisor|.
REQ-024 Divisor = 0 SHALL give quotient = all ones, remainder = dividend, div_by_zero=1, with the same latency.
REQ-025 With SIGNED=1, most-negative / -1 SHALL give quotient = most-negative (wrap), remainder = 0, div_by_zero=0.
REQ-026 start while busy SHALL be ignored: no state, operand or output change.
REQ-027 start asserted in the DONE cycle SHALL be ignored; a new start is accepted in IDLE the following cycle.
REQ-028 Magnitude of most-negative SHALL be handled as a W-bit unsigned value without overflow.

Reset
REQ-029 rst=1 at any rising edge SHALL force IDLE and clear busy, done, quotient, remainder, div_by_zero and the counter to 0.
REQ-030 Reset mid-operation SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-031 rst SHALL take priority over start in the same cycle.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration and the default W constant.
REQ-033 One combinational sub-module, div_step, SHALL implement a single non-restoring iteration.
REQ-034 div_step inputs SHALL be partial remainder, shifted-in dividend bit and divisor magnitude.
REQ-035 div_step outputs SHALL be the next partial remainder and the quotient bit.
REQ-036 seq_div SHALL instantiate div_step once and reuse it every CALC cycle.

Verification (W=32)
REQ-037 SIGNED=1, 100/7 -> quotient=14, remainder=2, done exactly 34 cycles after accept.
REQ-038 SIGNED=1, -100/7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE).
REQ-039 SIGNED=1, 7/0 -> quotient=0xFFFFFFFF, remainder=7, div_by_zero=1.
REQ-040 SIGNED=1, 0x80000000/-1 -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-041 SIGNED=0, 0xFFFFFFFF/2 -> quotient=0x7FFFFFFF, remainder=1.
REQ-042 start pulsed again mid-CALC -> ignored; first result unchanged.
REQ-043 rst asserted 10 cycles after accept -> busy=0 next cycle, no done, all outputs 0.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and default width.
package seq_div_pkg;

  localparam int DEFAULT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 non-restoring division iteration on a (W+1)-bit signed partial remainder.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   pr_in,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor_mag,
  output logic [W:0]   pr_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] divisor_ext;

  // Top bit of the shift is dropped; the result always fits in W+1 signed bits,
  // so modular arithmetic gives the exact next remainder.
  always_comb begin
    shifted     = {pr_in[W-1:0], dividend_bit};
    divisor_ext = {1'b0, divisor_mag};
    pr_out      = pr_in[W] ? (shifted + divisor_ext) : (shifted - divisor_ext);
    q_bit       = ~pr_out[W];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential radix-2 non-restoring divider, one quotient bit per cycle,
// signed (truncating) or unsigned, with divide-by-zero flagging.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on accept
//   CALC  | W non-restoring iterations, one per cycle
//   FIX   | remainder restore, sign correction, results registered
//   DONE  | done pulse for one cycle, then back to IDLE
module seq_div
  import seq_div_pkg::*;
#(
  parameter int W      = DEFAULT_W,
  parameter bit SIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  state_t state;
  state_t state_next;

  logic [CW-1:0] count;
  logic [W:0]    pr;
  logic [W-1:0]  q_work;
  logic [W-1:0]  divisor_mag;
  logic [W-1:0]  dividend_raw;
  logic          a_neg;
  logic          b_neg;

  logic [W:0]    pr_step;
  logic          q_bit;

  logic          in_a_neg;
  logic          in_b_neg;
  logic [W-1:0]  dividend_mag_in;
  logic [W-1:0]  divisor_mag_in;
  logic [W-1:0]  rem_mag;
  logic [W-1:0]  quo_fix;
  logic [W-1:0]  rem_fix;
  logic          zero_div;
  logic          last_step;

  div_step #(.W(W)) u_step (
    .pr_in        (pr),
    .dividend_bit (q_work[W-1]),
    .divisor_mag  (divisor_mag),
    .pr_out       (pr_step),
    .q_bit        (q_bit)
  );

  // Most-negative negates to itself, which is exactly its W-bit unsigned magnitude.
  always_comb begin
    in_a_neg        = SIGNED && dividend[W-1];
    in_b_neg        = SIGNED && divisor[W-1];
    dividend_mag_in = in_a_neg ? (-dividend) : dividend;
    divisor_mag_in  = in_b_neg ? (-divisor) : divisor;
  end

  always_comb begin
    zero_div  = (divisor_mag == '0);
    last_step = (count == CW'(1));
    rem_mag   = pr[W] ? (pr[W-1:0] + divisor_mag) : pr[W-1:0];
    quo_fix   = (a_neg ^ b_neg) ? (-q_work) : q_work;
    rem_fix   = a_neg ? (-rem_mag) : rem_mag;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      pr           <= '0;
      q_work       <= '0;
      divisor_mag  <= '0;
      dividend_raw <= '0;
      a_neg        <= 1'b0;
      b_neg        <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_neg        <= in_a_neg;
            b_neg        <= in_b_neg;
            dividend_raw <= dividend;
            divisor_mag  <= divisor_mag_in;
            q_work       <= dividend_mag_in;
            pr           <= '0;
            count        <= CW'(W);
          end
        end
        CALC: begin
          pr     <= pr_step;
          q_work <= {q_work[W-2:0], q_bit};
          count  <= count - CW'(1);
        end
        FIX: begin
          quotient    <= zero_div ? '1 : quo_fix;
          remainder   <= zero_div ? dividend_raw : rem_fix;
          div_by_zero <= zero_div;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: one signed and one unsigned instance, W=32.
module tb_seq_div;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_s, start_u;
  logic [W-1:0] a_s, b_s, a_u, b_u;
  logic         busy_s, done_s, dbz_s;
  logic         busy_u, done_u, dbz_u;
  logic [W-1:0] quo_s, rem_s, quo_u, rem_u;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done_s = 0;
  exp_t sb_s[$];
  exp_t sb_u[$];
  exp_t e_s, e_u;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_div #(.W(W), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .dividend(a_s), .divisor(b_s),
    .busy(busy_s), .done(done_s), .quotient(quo_s), .remainder(rem_s),
    .div_by_zero(dbz_s)
  );

  seq_div #(.W(W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .start(start_u), .dividend(a_u), .divisor(b_u),
    .busy(busy_u), .done(done_u), .quotient(quo_u), .remainder(rem_u),
    .div_by_zero(dbz_u)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    n_checks++;
    if (obs !== expd) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expd);
    end
  endtask

  function automatic exp_t model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int c);
    exp_t e;
    int   sa, sb;
    e.cyc = c;
    e.dbz = 1'b0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a;
      e.r = '0;
    end else if (sgn) begin
      sa  = $signed(a);
      sb  = $signed(b);
      e.q = sa / sb;
      e.r = sa % sb;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done_s) begin
      n_done_s++;
      if (sb_s.size() == 0) begin
        check("s_spurious_done", 64'(done_s), 64'd0);
      end else begin
        e_s = sb_s.pop_front();
        check("s_quotient", 64'(quo_s), 64'(e_s.q));
        check("s_remainder", 64'(rem_s), 64'(e_s.r));
        check("s_div_by_zero", 64'(dbz_s), 64'(e_s.dbz));
        check("s_latency", 64'(cyc - e_s.cyc), 64'(LAT));
        check("s_busy_at_done", 64'(busy_s), 64'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (done_u) begin
      if (sb_u.size() == 0) begin
        check("u_spurious_done", 64'(done_u), 64'd0);
      end else begin
        e_u = sb_u.pop_front();
        check("u_quotient", 64'(quo_u), 64'(e_u.q));
        check("u_remainder", 64'(rem_u), 64'(e_u.r));
        check("u_div_by_zero", 64'(dbz_u), 64'(e_u.dbz));
        check("u_latency", 64'(cyc - e_u.cyc), 64'(LAT));
      end
    end
  end

  task automatic drive(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b, input logic st);
    if (sgn) begin
      start_s = st; a_s = a; b_s = b;
    end else begin
      start_u = st; a_u = a; b_u = b;
    end
  endtask

  task automatic push(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    if (sgn) sb_s.push_back(model(1'b1, a, b, cyc));
    else     sb_u.push_back(model(1'b0, a, b, cyc));
  endtask

  task automatic wait_done(input bit sgn);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (sgn ? done_s : done_u) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic release_start(input bit sgn);
    if (sgn) start_s = 1'b0;
    else     start_u = 1'b0;
  endtask

  task automatic run(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    drive(sgn, a, b, 1'b1);
    push(sgn, a, b);
    @(negedge clk);
    release_start(sgn);
    check("busy_after_accept", 64'(sgn ? busy_s : busy_u), 64'd1);
    wait_done(sgn);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           done_before;

    rst = 1'b1;
    drive(1'b1, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy_s), 64'd0);
    check("rst_done", 64'(done_s), 64'd0);
    check("rst_quotient", 64'(quo_s), 64'd0);
    check("rst_remainder", 64'(rem_s), 64'd0);
    check("rst_div_by_zero", 64'(dbz_s), 64'd0);

    // signed directed cases
    run(1'b1, 32'd100, 32'd7);
    run(1'b1, -32'd100, 32'd7);
    run(1'b1, 32'd100, -32'd7);
    run(1'b1, -32'd100, -32'd7);
    run(1'b1, 32'd7, 32'd0);
    run(1'b1, -32'd7, 32'd0);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run(1'b1, 32'h8000_0000, 32'd1);
    run(1'b1, 32'h8000_0000, 32'd7);
    run(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    run(1'b1, 32'd0, 32'd5);
    run(1'b1, -32'd5, 32'd7);
    run(1'b1, 32'd5, 32'h8000_0000);

    // unsigned directed cases
    run(1'b0, 32'hFFFF_FFFF, 32'd2);
    run(1'b0, 32'hFFFF_FFFF, 32'd1);
    run(1'b0, 32'd10, 32'd0);
    run(1'b0, 32'd3, 32'hFFFF_FFFF);
    run(1'b0, 32'h8000_0000, 32'h8000_0000);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 1) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 4 == 3) rb = -rb;
      run(1'b1, ra, rb);
      run(1'b0, ra, rb);
    end

    // start pulsed mid-CALC must not disturb the running operation
    @(negedge clk);
    drive(1'b1, 32'd100, 32'd7, 1'b1);
    push(1'b1, 32'd100, 32'd7);
    @(negedge clk);
    start_s = 1'b0;
    repeat (5) @(negedge clk);
    drive(1'b1, 32'd999, 32'd3, 1'b1);
    @(negedge clk);
    start_s = 1'b0;
    check("busy_mid_calc", 64'(busy_s), 64'd1);
    wait_done(1'b1);

    // start in the DONE cycle is ignored, then accepted in the following IDLE cycle
    run(1'b1, 32'd1000, 32'd10);
    drive(1'b1, 32'd55, 32'd5, 1'b1);
    @(negedge clk);
    check("idle_after_done", 64'(busy_s), 64'd0);
    push(1'b1, 32'd55, 32'd5);
    @(negedge clk);
    start_s = 1'b0;
    check("busy_after_done_start", 64'(busy_s), 64'd1);
    wait_done(1'b1);

    // reset 10 cycles after accept aborts the operation
    @(negedge clk);
    drive(1'b1, 32'd12345, 32'd67, 1'b1);
    push(1'b1, 32'd12345, 32'd67);
    @(negedge clk);
    start_s = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb_s.delete();
    done_before = n_done_s;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy_s), 64'd0);
    check("abort_done", 64'(done_s), 64'd0);
    check("abort_quotient", 64'(quo_s), 64'd0);
    check("abort_remainder", 64'(rem_s), 64'd0);
    check("abort_div_by_zero", 64'(dbz_s), 64'd0);
    repeat (LAT + 5) @(negedge clk);
    check("abort_no_done", 64'(n_done_s), 64'(done_before));

    // rst wins over start in the same cycle
    drive(1'b1, 32'd9, 32'd3, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_s = 1'b0;
    check("rst_over_start_busy", 64'(busy_s), 64'd0);

    run(1'b1, 32'd81, 32'd9);

    repeat (3) @(negedge clk);
    check("sb_s_empty", 64'(sb_s.size()), 64'd0);
    check("sb_u_empty", 64'(sb_u.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
